// File: rtl/uart_tx_word_sequencer_if.sv
// uart_tx_word_sequencer_if
//   Bundles the CPU write port, the transmitter byte port and the status and
//   debug signals of uart_tx_word_sequencer.
//
//   Handshake rule for the write port: a word moves on a rising clock edge
//   when wr_valid and wr_ready are both high. wr_ready depends only on the
//   FIFO fill level and never on wr_valid. A word offered while wr_ready is
//   low is dropped and sets the sticky overflow flag.
//
//   Signals:
//     wr_data/wr_valid/wr_ready  CPU word port (byte0 = wr_data[7:0] goes first)
//     clr_overflow/overflow      sticky overflow flag and its synchronous clear
//     tx_byte/tx_start/tx_done   byte port towards the UART serializer
//     busy/fifo_count            status
//     dbg_state/dbg_byte_idx     FSM state and byte index, for observation
//
//   Modports: master = CPU/transmitter side, slave = the sequencer.
interface uart_tx_word_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          clr_overflow;
    logic          overflow;
    logic [7:0]    tx_byte;
    logic          tx_start;
    logic          tx_done;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic [1:0]    dbg_state;
    logic [1:0]    dbg_byte_idx;

    modport master (
        output wr_data, wr_valid, clr_overflow, tx_done,
        input  wr_ready, overflow, tx_byte, tx_start, busy, fifo_count,
               dbg_state, dbg_byte_idx
    );

    modport slave (
        input  wr_data, wr_valid, clr_overflow, tx_done,
        output wr_ready, overflow, tx_byte, tx_start, busy, fifo_count,
               dbg_state, dbg_byte_idx
    );
endinterface

// File: rtl/uart_tx_word_sequencer.sv
// uart_tx_word_sequencer
//   Buffers 32-bit words from the CPU in a DEPTH-entry FIFO and feeds them to
//   a byte-wide UART transmitter, least significant byte first. Each byte is
//   launched with a one-cycle tx_start and the next byte waits for tx_done.
//
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous, active-high
//     bus    uart_tx_word_sequencer_if.slave (write port, byte port, status,
//            debug state)
module uart_tx_word_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    uart_tx_word_sequencer_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD      = 2'd1;
    localparam logic [1:0] S_START     = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [31:0]   mem_q [DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    state_q, state_d;
    logic [31:0]   holding_q, holding_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          overflow_q, overflow_d;

    logic [CW-1:0] count;
    logic          wr_ready;
    logic          push;
    logic          pop;
    logic [31:0]   head;
    logic [1:0]    idx_nxt;

    // Pointers carry one extra bit so a full FIFO (difference == DEPTH) is
    // distinguishable from an empty one (difference == 0).
    assign count    = wr_ptr_q - rd_ptr_q;
    assign wr_ready = (count < CW'(DEPTH));
    assign push     = bus.wr_valid && wr_ready;
    // Only LOAD pops, and LOAD is entered only with a non-empty FIFO.
    assign pop      = (state_q == S_LOAD);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign idx_nxt  = byte_idx_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        holding_d  = holding_q;
        byte_idx_d = byte_idx_q;
        tx_byte_d  = tx_byte_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (count != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                holding_d  = head;
                byte_idx_d = 2'd0;
                // Byte 0 is registered now so it is already valid in START.
                tx_byte_d  = head[7:0];
                state_d    = S_START;
            end
            S_START: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.tx_done) begin
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = idx_nxt;
                        tx_byte_d  = holding_q[{idx_nxt, 3'b000} +: 8];
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A dropped write sets the flag even if a clear arrives in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (bus.wr_valid && !wr_ready) begin
            overflow_d = 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            holding_q  <= '0;
            byte_idx_q <= 2'd0;
            tx_byte_q  <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            holding_q  <= holding_d;
            byte_idx_q <= byte_idx_d;
            tx_byte_q  <= tx_byte_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
        end
    end

    assign bus.wr_ready     = wr_ready;
    assign bus.overflow     = overflow_q;
    assign bus.tx_byte      = tx_byte_q;
    assign bus.tx_start     = (state_q == S_START);
    assign bus.busy         = (state_q != S_IDLE) || (count != '0);
    assign bus.fifo_count   = count;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_byte_idx = byte_idx_q;
endmodule

// File: tb/tb_uart_tx_word_sequencer.sv
module tb_uart_tx_word_sequencer;
    localparam int DEPTH = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_START = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_tx_word_sequencer_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_word_sequencer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- bookkeeping ----------------
    int  n_vec     = 0;
    int  n_mis     = 0;
    int  start_cnt = 0;
    int  done_cd   = 0;
    int  s0        = 0;
    bit  auto_done = 1'b0;
    bit  spur      = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: wait for the falling edge, record any launched byte, then
    // drive tx_done for the coming rising edge (done model + spurious pulse).
    task automatic step();
        @(negedge clock);
        if (bus.tx_start === 1'b1) begin
            obs_q.push_back(bus.tx_byte);
            start_cnt++;
            if (auto_done) done_cd = 10;
        end
        bus.tx_done = 1'b0;
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) bus.tx_done = 1'b1;
        end
        if (spur) begin
            bus.tx_done = 1'b1;
            spur = 1'b0;
        end
    endtask

    task automatic write_word(input logic [31:0] w);
        bus.wr_valid = 1'b1;
        bus.wr_data  = w;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.busy !== 1'b1) break;
            step();
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    // Scoreboard drain: compare launched bytes against the expected queue.
    task automatic compare_bytes(input string tag);
        check({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check({tag, "_byte"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.wr_data      = '0;
        bus.wr_valid     = 1'b0;
        bus.clr_overflow = 1'b0;
        bus.tx_done      = 1'b0;

        // Reset state
        step();
        step();
        check("rst_count",    32'(bus.fifo_count), 32'd0);
        check("rst_ready",    32'(bus.wr_ready),   32'd1);
        check("rst_busy",     32'(bus.busy),       32'd0);
        check("rst_start",    32'(bus.tx_start),   32'd0);
        check("rst_byte",     32'(bus.tx_byte),    32'd0);
        check("rst_overflow", 32'(bus.overflow),   32'd0);
        reset = 1'b0;
        step();

        // Single word, latency and byte order
        auto_done = 1'b1;
        s0 = start_cnt;
        expect_word(32'hA1B2C3D4);
        write_word(32'hA1B2C3D4);
        check("w1_count_n",  32'(bus.fifo_count), 32'd1);
        check("w1_state_n",  32'(bus.dbg_state),  32'(ST_IDLE));
        check("w1_busy_n",   32'(bus.busy),       32'd1);
        step();
        check("w1_state_n1", 32'(bus.dbg_state),  32'(ST_LOAD));
        check("w1_count_n1", 32'(bus.fifo_count), 32'd1);
        step();
        check("w1_start_n2", 32'(bus.tx_start),   32'd1);
        check("w1_byte_n2",  32'(bus.tx_byte),    32'hD4);
        check("w1_count_n2", 32'(bus.fifo_count), 32'd0);
        step();
        check("w1_start_off", 32'(bus.tx_start),  32'd0);
        check("w1_byte_hold", 32'(bus.tx_byte),   32'hD4);
        wait_idle("w1", 200);
        check("w1_starts", 32'(start_cnt - s0), 32'd4);
        compare_bytes("w1");

        // Fill the FIFO with tx_done held low; 6th word is dropped
        auto_done = 1'b0;
        s0 = start_cnt;
        expect_word(32'h11111111);
        expect_word(32'h22222222);
        expect_word(32'h33333333);
        expect_word(32'h44444444);
        expect_word(32'h55555555);
        write_word(32'h11111111);
        write_word(32'h22222222);
        write_word(32'h33333333);
        write_word(32'h44444444);
        write_word(32'h55555555);
        check("fill_count5", 32'(bus.fifo_count), 32'd4);
        check("fill_ovf5",   32'(bus.overflow),   32'd0);
        write_word(32'h66666666);
        check("fill_count",  32'(bus.fifo_count), 32'd4);
        check("fill_ready",  32'(bus.wr_ready),   32'd0);
        check("fill_ovf",    32'(bus.overflow),   32'd1);
        check("fill_state",  32'(bus.dbg_state),  32'(ST_WAIT));
        check("fill_byte",   32'(bus.tx_byte),    32'h11);

        // Overflow priority and clear
        bus.wr_valid     = 1'b1;
        bus.wr_data      = 32'h77777777;
        bus.clr_overflow = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        check("ovf_set_wins", 32'(bus.overflow),   32'd1);
        check("ovf_count",    32'(bus.fifo_count), 32'd4);
        step();
        bus.clr_overflow = 1'b0;
        check("ovf_cleared",  32'(bus.overflow),   32'd0);
        auto_done = 1'b1;
        done_cd   = 3;
        wait_idle("drain", 1000);
        check("drain_starts", 32'(start_cnt - s0), 32'd20);
        compare_bytes("drain");

        // Push and pop in the same cycle
        auto_done = 1'b0;
        s0 = start_cnt;
        expect_word(32'h0A0B0C0D);
        expect_word(32'h1A1B1C1D);
        expect_word(32'h2A2B2C2D);
        write_word(32'h0A0B0C0D);
        write_word(32'h1A1B1C1D);
        check("pp_count_pre", 32'(bus.fifo_count), 32'd2);
        check("pp_state_pre", 32'(bus.dbg_state),  32'(ST_LOAD));
        write_word(32'h2A2B2C2D);
        check("pp_count",     32'(bus.fifo_count), 32'd2);
        check("pp_state",     32'(bus.dbg_state),  32'(ST_START));
        step();
        auto_done = 1'b1;
        done_cd   = 3;
        wait_idle("pp", 1000);
        check("pp_starts", 32'(start_cnt - s0), 32'd12);
        compare_bytes("pp");

        // Spurious tx_done in IDLE and in START
        auto_done = 1'b0;
        s0 = start_cnt;
        spur = 1'b1;
        step();
        step();
        check("sp_idle_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("sp_idle_busy",  32'(bus.busy),      32'd0);
        check("sp_idle_start", 32'(start_cnt - s0), 32'd0);
        expect_word(32'hDEADBEEF);
        write_word(32'hDEADBEEF);
        step();
        spur = 1'b1;
        step();
        check("sp_start_seen", 32'(bus.tx_start), 32'd1);
        step();
        check("sp_wait_state", 32'(bus.dbg_state),    32'(ST_WAIT));
        check("sp_wait_idx",   32'(bus.dbg_byte_idx), 32'd0);
        step();
        step();
        step();
        check("sp_no_extra", 32'(start_cnt - s0), 32'd1);
        auto_done = 1'b1;
        done_cd   = 3;
        wait_idle("sp", 500);
        check("sp_starts", 32'(start_cnt - s0), 32'd4);
        compare_bytes("sp");

        // Reset mid-frame at byte_idx 2 with two words queued
        auto_done = 1'b0;
        write_word(32'h44332211);
        write_word(32'h88776655);
        write_word(32'hCCBBAA99);
        step();
        spur = 1'b1;
        step();
        step();
        step();
        spur = 1'b1;
        step();
        step();
        step();
        check("mr_state", 32'(bus.dbg_state),    32'(ST_WAIT));
        check("mr_idx",   32'(bus.dbg_byte_idx), 32'd2);
        check("mr_count", 32'(bus.fifo_count),   32'd2);
        check("mr_byte",  32'(bus.tx_byte),      32'h33);
        #2;
        reset = 1'b1;
        #1;
        check("ar_state", 32'(bus.dbg_state),    32'(ST_IDLE));
        check("ar_idx",   32'(bus.dbg_byte_idx), 32'd0);
        check("ar_count", 32'(bus.fifo_count),   32'd0);
        check("ar_byte",  32'(bus.tx_byte),      32'd0);
        check("ar_start", 32'(bus.tx_start),     32'd0);
        check("ar_busy",  32'(bus.busy),         32'd0);
        check("ar_ready", 32'(bus.wr_ready),     32'd1);
        check("ar_ovf",   32'(bus.overflow),     32'd0);
        step();
        step();
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        s0 = start_cnt;
        spur = 1'b1;
        step();
        step();
        check("pr_idle_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("pr_idle_start", 32'(start_cnt - s0), 32'd0);
        auto_done = 1'b1;
        expect_word(32'h00000055);
        write_word(32'h00000055);
        wait_idle("pr", 500);
        check("pr_starts", 32'(start_cnt - s0), 32'd4);
        compare_bytes("pr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/uart_tx_word_sequencer.md
Name: uart_tx_word_sequencer

Overview:
- Sits between the MIPS store path and the UART transmitter. Accepts 32-bit words from the CPU through a valid/ready port and buffers them in a small FIFO.
- Each word is split into four bytes, sent LSB byte first. Each byte is presented to the transmitter with a one-cycle start pulse, and the block waits for the transmitter's done pulse before moving to the next byte.
- The transmitter stays a pure byte serializer; this block owns the word-to-byte sequencing and the flow control.

Parameters:
- DEPTH, 4: FIFO depth in 32-bit words; power of two, 2..16.
- CW, $clog2(DEPTH)+1: width of the fifo_count port; derived, not overridden.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_data  in  32  word to transmit; byte0 = wr_data[7:0] is sent first.
- wr_valid  in  1  CPU presents wr_data.
- wr_ready  out  1  FIFO can accept a word; equals (fifo_count < DEPTH).
- clr_overflow  in  1  synchronous clear for the overflow flag.
- overflow  out  1  sticky; set when wr_valid=1 while wr_ready=0.
- tx_byte  out  8  byte for the transmitter; held stable from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse that launches a frame.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- fifo_count  out  CW  number of words held in the FIFO (does not include the word being sent).

Behaviour:
- Reset (async, any state, mid-frame included): FSM=IDLE; FIFO pointers=0; fifo_count=0; holding reg=0; byte_idx=0; tx_byte=0; tx_start=0; overflow=0; busy=0; wr_ready=1.
- A word in flight at reset is discarded. A tx_done pulse arriving after reset while IDLE is ignored.
- Write: accepted on a rising edge when wr_valid & wr_ready. Write pointer increments and wraps modulo DEPTH.
- Full FIFO: wr_ready=0 even if a pop happens in the same cycle (no bypass). The write is dropped, overflow is set, FIFO contents are unchanged.
- overflow priority: a set in the same cycle as clr_overflow wins.
- Simultaneous push and pop: fifo_count is unchanged, both pointers advance.
- FSM states: IDLE, LOAD, START, WAIT_DONE.
  - IDLE: if fifo_count>0, go to LOAD.
  - LOAD: pop the FIFO head into a 32-bit holding reg, byte_idx=0, go to START.
  - START: tx_start=1 for exactly this cycle; tx_byte=holding[8*byte_idx+:8] is registered on entry, so it is valid during START; go to WAIT_DONE.
  - WAIT_DONE: tx_start=0, tx_byte held. On tx_done: if byte_idx<3, byte_idx+1 and go to START; if byte_idx==3, go to IDLE.
- tx_done in any state other than WAIT_DONE is ignored.
- Latency: word accepted at edge N, FIFO and FSM idle → LOAD in cycle N+1, tx_start high in cycle N+2 with byte0.
  - tx_done seen in cycle M → next tx_start in cycle M+1.
  - Between words: last tx_done in cycle M → IDLE in M+1, LOAD in M+2, START in M+3.
- fifo_count range 0..DEPTH; never wraps. Pointers use CW bits so full and empty are distinguishable.
- busy is combinational from the state and fifo_count.
- wr_ready is combinational from fifo_count only, never from wr_valid.

Test Plan:
- Single word: write 0xA1B2C3D4 from idle; done model pulses tx_done 10 cycles after each start → tx_start at N+2 with tx_byte=0xD4, then 0xC3, 0xB2, 0xA1; exactly 4 pulses; busy falls after the 4th tx_done; fifo_count 1→0 at the LOAD edge.
- Fill: hold tx_done=0, write 0x11111111 … 0x66666666 back-to-back → 1st word popped into the holding reg, FIFO holds 4 words, fifo_count=4, wr_ready=0, 6th word dropped, overflow=1.
- Overflow handling: with overflow=1, assert clr_overflow together with a dropped write → overflow stays 1; clr_overflow alone → 0. Then drain → bytes match the accepted words in order; the dropped word never appears.
- Push/pop same cycle: FIFO at 2 words, write coincides with the LOAD edge → fifo_count stays 2; order preserved, including pointer wrap after more than DEPTH total writes.
- Spurious done: pulse tx_done during IDLE and during START → no byte_idx advance, no extra tx_start.
- Reset mid-frame: assert reset in WAIT_DONE with byte_idx=2 and 2 words queued → all outputs reach reset values immediately (asynchronous); after release a new write of 0x00000055 sends 0x55, 0x00, 0x00, 0x00 only.
